j_acc_shifter_mx_cell: RTL and testbench

Bit-serial word streamer for 32 accumulator channels. On `shift_start` it reads `img_size+1` consecutive 32-bit words per channel from a single-port SRAM, beginning at each channel's `start_addr`. Each word is emitted LSB-first on that channel's `serial_output` bit, qualified by `serial_en`. It is the reader/transmitter counterpart of `j_acc_deshifter_MX_cell`: its serial outputs feed that block's `serial_input`/`serial_en`, so a memory image round-trips unchanged.

---
 rtl/j_acc_shifter_mx_cell.sv | 185 ++++++++++++++++++
 tb/tb_j_acc_shifter_mx_cell.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/j_acc_shifter_mx_cell.sv
// Bit-serial word streamer: reads per-channel SRAM words round-robin
// and emits them LSB-first on 32 serial lanes.
module j_acc_shifter_mx_cell #(
  parameter int SRAM_DEPTH = 1024,
  parameter int ADDR_W     = $clog2(SRAM_DEPTH),
  parameter int CHANNELS   = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       shift_start,
  input  logic [ADDR_W*CHANNELS-1:0] start_addr,
  input  logic [ADDR_W-1:0]          img_size,
  output logic                       shift_idle,
  output logic                       sram_en,
  output logic [ADDR_W-1:0]          sram_addr,
  input  logic [31:0]                sram_data,
  output logic [CHANNELS-1:0]        serial_output,
  output logic [CHANNELS-1:0]        serial_en
);

  localparam int CW = $clog2(CHANNELS);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state;

  logic [ADDR_W-1:0] addr_q [CHANNELS];
  logic [ADDR_W:0]   rem_q  [CHANNELS];
  logic [31:0]       hold_q [CHANNELS];
  logic [31:0]       sh_q   [CHANNELS];
  logic [4:0]        cnt_q  [CHANNELS];
  logic [CHANNELS-1:0] pend_q;
  logic [CHANNELS-1:0] hold_v;
  logic [CHANNELS-1:0] sh_v;
  logic [CW-1:0]     ptr_q;
  logic [CW-1:0]     iss_ch;
  logic [CW-1:0]     ret_ch;
  logic              ret_v;

  logic              start_go;
  logic              active;
  logic [ADDR_W-1:0] addr_c [CHANNELS];
  logic [ADDR_W:0]   rem_c  [CHANNELS];
  logic [CW-1:0]     ptr_c;
  logic [CHANNELS-1:0] elig;
  logic [CHANNELS-1:0] cap;
  logic              gnt_v;
  logic [CW-1:0]     gnt_ch;
  logic              rem_zero;
  logic              done;

  assign start_go = (state == IDLE) && shift_start;
  assign active   = start_go || (state == RUN);
  assign ptr_c    = start_go ? '0 : ptr_q;

  // The start edge itself acts as a grant edge, so channel 0 is read
  // in the very first cycle of the job.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      addr_c[i] = start_go ? start_addr[i*ADDR_W +: ADDR_W] : addr_q[i];
      rem_c[i]  = start_go ? {1'b0, img_size} + (ADDR_W+1)'(1) : rem_q[i];
      elig[i]   = active && (rem_c[i] != '0) && !hold_v[i] && !pend_q[i];
    end
  end

  always_comb begin
    logic [CW-1:0] idx;
    idx    = '0;
    gnt_v  = 1'b0;
    gnt_ch = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = ptr_c + CW'(k);
      if (!gnt_v && elig[idx]) begin
        gnt_v  = 1'b1;
        gnt_ch = idx;
      end
    end
  end

  always_comb begin
    cap = '0;
    if (ret_v) cap[ret_ch] = 1'b1;
  end

  always_comb begin
    rem_zero = 1'b1;
    for (int i = 0; i < CHANNELS; i++)
      if (rem_q[i] != '0) rem_zero = 1'b0;
    done = rem_zero && (pend_q == '0) && (hold_v == '0) && (sh_v == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      shift_idle <= 1'b1;
      sram_en    <= 1'b0;
      sram_addr  <= '0;
      ptr_q      <= '0;
      iss_ch     <= '0;
      ret_v      <= 1'b0;
      ret_ch     <= '0;
    end else begin
      sram_en <= gnt_v;
      ret_v   <= sram_en;
      ret_ch  <= iss_ch;
      if (gnt_v) begin
        sram_addr <= addr_c[gnt_ch];
        iss_ch    <= gnt_ch;
        ptr_q     <= gnt_ch + CW'(1);
      end
      case (state)
        IDLE: if (shift_start) begin
          state      <= RUN;
          shift_idle <= 1'b0;
        end
        RUN: if (done) begin
          state      <= IDLE;
          shift_idle <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        addr_q[i] <= '0;
        rem_q[i]  <= '0;
        hold_q[i] <= '0;
        sh_q[i]   <= '0;
        cnt_q[i]  <= '0;
      end
      pend_q <= '0;
      hold_v <= '0;
      sh_v   <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (gnt_v && gnt_ch == CW'(i)) begin
          addr_q[i] <= addr_c[i] + ADDR_W'(1);
          rem_q[i]  <= rem_c[i] - (ADDR_W+1)'(1);
          pend_q[i] <= 1'b1;
        end else if (start_go) begin
          addr_q[i] <= addr_c[i];
          rem_q[i]  <= rem_c[i];
        end
        if (cap[i]) pend_q[i] <= 1'b0;

        if (sh_v[i]) begin
          if (cnt_q[i] == 5'd31) begin
            cnt_q[i] <= '0;
            if (cap[i]) begin
              sh_q[i] <= sram_data;
            end else if (hold_v[i]) begin
              sh_q[i]   <= hold_q[i];
              hold_v[i] <= 1'b0;
            end else begin
              sh_q[i] <= '0;
              sh_v[i] <= 1'b0;
            end
          end else begin
            sh_q[i]  <= sh_q[i] >> 1;
            cnt_q[i] <= cnt_q[i] + 5'd1;
            if (cap[i]) begin
              hold_q[i] <= sram_data;
              hold_v[i] <= 1'b1;
            end
          end
        end else if (cap[i]) begin
          sh_q[i]  <= sram_data;
          sh_v[i]  <= 1'b1;
          cnt_q[i] <= '0;
        end
      end
    end
  end

  // Shift register is zeroed whenever idle, so bit 0 is already 0 off-word.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++)
      serial_output[i] = sh_q[i][0];
  end

  assign serial_en = sh_v;

endmodule

// File: tb/tb_j_acc_shifter_mx_cell.sv
// Bench for j_acc_shifter_mx_cell: SRAM model, per-channel word
// scoreboard and a behavioural deserialiser for the round trip.
module tb_j_acc_shifter_mx_cell;

  localparam int AW  = 10;
  localparam int NCH = 32;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            shift_start = 1'b0;
  logic [AW*NCH-1:0] start_addr = '0;
  logic [AW-1:0]   img_size = '0;
  logic            shift_idle;
  logic            sram_en;
  logic [AW-1:0]   sram_addr;
  logic [31:0]     sram_data = '0;
  logic [NCH-1:0]  serial_output;
  logic [NCH-1:0]  serial_en;

  always #5 clk = ~clk;

  j_acc_shifter_mx_cell dut (
    .clk(clk),
    .reset_n(reset_n),
    .shift_start(shift_start),
    .start_addr(start_addr),
    .img_size(img_size),
    .shift_idle(shift_idle),
    .sram_en(sram_en),
    .sram_addr(sram_addr),
    .sram_data(sram_data),
    .serial_output(serial_output),
    .serial_en(serial_en)
  );

  logic [31:0] mem [1024];
  logic [31:0] dst [1024];

  always @(posedge clk) if (sram_en) sram_data <= mem[sram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q [NCH][$];
  logic [31:0] rx [NCH];
  int          nb [NCH];
  int          first_en [NCH];
  logic [9:0]  dst_a [NCH];
  logic [9:0]  sa_arr [NCH];
  logic [9:0]  addr_log [$];
  logic [31:0] mon_w;
  int          en_cnt = 0;
  int          e0 = 0;
  bit          mon_on = 1'b0;

  always @(negedge clk) begin
    if (mon_on) begin
      if (sram_en) begin
        en_cnt++;
        addr_log.push_back(sram_addr);
      end
      for (int i = 0; i < NCH; i++) begin
        if (serial_en[i]) begin
          if (first_en[i] < 0) first_en[i] = cyc;
          rx[i] = {serial_output[i], rx[i][31:1]};
          nb[i]++;
          if (nb[i] == 32) begin
            nb[i] = 0;
            checks++;
            if (exp_q[i].size() == 0) begin
              errors++;
              $display("FAIL extra_word ch%0d got %h required none", i, rx[i]);
            end else begin
              mon_w = exp_q[i].pop_front();
              if (rx[i] !== mon_w) begin
                errors++;
                $display("FAIL word ch%0d got %h required %h", i, rx[i], mon_w);
              end
            end
            dst[dst_a[i]] = rx[i];
            dst_a[i] = dst_a[i] + 10'd1;
          end
        end else begin
          if (nb[i] != 0) begin
            checks++;
            errors++;
            $display("FAIL word_gap ch%0d got gap after %0d bits required 32 consecutive", i, nb[i]);
            nb[i] = 0;
          end
          if (serial_output[i] !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL out_when_off ch%0d got %b required 0", i, serial_output[i]);
          end
        end
      end
    end
  end

  task automatic fill_linear();
    for (int a = 0; a < 1024; a++) mem[a] = 32'(a);
  endtask

  task automatic fill_hash();
    for (int a = 0; a < 1024; a++) mem[a] = $urandom;
  endtask

  task automatic set_sa_blocks();
    for (int i = 0; i < NCH; i++) sa_arr[i] = 10'(i << 5);
  endtask

  task automatic start_job(input logic [9:0] isz);
    logic [9:0] a;
    @(negedge clk);
    for (int i = 0; i < NCH; i++) begin
      start_addr[i*AW +: AW] = sa_arr[i];
      exp_q[i].delete();
      nb[i] = 0;
      first_en[i] = -1;
      dst_a[i] = sa_arr[i];
      for (int j = 0; j <= int'(isz); j++) begin
        a = sa_arr[i] + 10'(j);
        exp_q[i].push_back(mem[a]);
      end
    end
    en_cnt = 0;
    addr_log.delete();
    img_size = isz;
    shift_start = 1'b1;
    mon_on = 1'b1;
    @(posedge clk);
    #1;
    shift_start = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 5000 && !ok; n++) begin
      @(negedge clk);
      if (shift_idle) ok = 1'b1;
    end
  endtask

  function automatic int leftover();
    int left = 0;
    for (int i = 0; i < NCH; i++) left += exp_q[i].size() + ((nb[i] != 0) ? 1 : 0);
    return left;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 5;
    if (shift_idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b required 1", shift_idle); end
    if (sram_en !== 1'b0) begin errors++; $display("FAIL reset_sram_en got %b required 0", sram_en); end
    if (sram_addr !== 10'd0) begin errors++; $display("FAIL reset_sram_addr got %0d required 0", sram_addr); end
    if (serial_en !== '0) begin errors++; $display("FAIL reset_serial_en got %h required 0", serial_en); end
    if (serial_output !== '0) begin errors++; $display("FAIL reset_serial_out got %h required 0", serial_output); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_image();
    bit ok;
    int seen;
    fill_linear();
    set_sa_blocks();
    start_job(10'd31);
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL full_idle got busy required idle within bound"); end
    checks++;
    if (leftover() != 0) begin errors++; $display("FAIL full_words got %0d undelivered required 0", leftover()); end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (serial_en != '0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL full_trailing got %0d enabled cycles required 0", seen); end
    checks++;
    if (shift_idle !== 1'b1) begin errors++; $display("FAIL full_idle_hold got %b required 1", shift_idle); end
  endtask

  task automatic test_min_size();
    bit ok;
    fill_hash();
    set_sa_blocks();
    start_job(10'd0);
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL min_idle got busy required idle within bound"); end
    checks++;
    if (leftover() != 0) begin errors++; $display("FAIL min_words got %0d undelivered required 0", leftover()); end
    checks++;
    if (en_cnt != 32) begin errors++; $display("FAIL min_reads got %0d required 32", en_cnt); end
  endtask

  task automatic test_latency();
    bit ok;
    fill_hash();
    for (int i = 0; i < NCH; i++) sa_arr[i] = 10'($urandom);
    start_job(10'd0);
    checks += 3;
    if (shift_idle !== 1'b0) begin errors++; $display("FAIL lat_idle got %b required 0", shift_idle); end
    if (sram_en !== 1'b1) begin errors++; $display("FAIL lat_first_en got %b required 1", sram_en); end
    if (sram_addr !== sa_arr[0]) begin errors++; $display("FAIL lat_first_addr got %0d required %0d", sram_addr, sa_arr[0]); end
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL lat_done got busy required idle within bound"); end
    checks += 3;
    if (first_en[0] - e0 != 2) begin errors++; $display("FAIL lat_ch0 got %0d required 2", first_en[0] - e0); end
    if (first_en[5] - first_en[0] != 5) begin errors++; $display("FAIL lat_ch5 got %0d required 5", first_en[5] - first_en[0]); end
    if (leftover() != 0) begin errors++; $display("FAIL lat_words got %0d undelivered required 0", leftover()); end
  endtask

  task automatic test_wrap();
    bit ok;
    fill_hash();
    set_sa_blocks();
    sa_arr[0] = 10'd1023;
    start_job(10'd1);
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_idle got busy required idle within bound"); end
    checks++;
    if (addr_log.size() != 64) begin
      errors++;
      $display("FAIL wrap_reads got %0d required 64", addr_log.size());
    end else begin
      checks++;
      if (addr_log[0] !== 10'd1023) begin errors++; $display("FAIL wrap_addr0 got %0d required 1023", addr_log[0]); end
      if (addr_log[32] !== 10'd0) begin errors++; $display("FAIL wrap_addr1 got %0d required 0", addr_log[32]); end
    end
    checks++;
    if (leftover() != 0) begin errors++; $display("FAIL wrap_words got %0d undelivered required 0", leftover()); end
  endtask

  task automatic test_start_busy();
    bit ok;
    fill_hash();
    set_sa_blocks();
    start_job(10'd3);
    repeat (50) @(negedge clk);
    img_size = 10'd7;
    shift_start = 1'b1;
    @(posedge clk);
    #1;
    shift_start = 1'b0;
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL busy_idle got busy required idle within bound"); end
    checks++;
    if (en_cnt != 128) begin errors++; $display("FAIL busy_reads got %0d required 128", en_cnt); end
    checks++;
    if (leftover() != 0) begin errors++; $display("FAIL busy_words got %0d undelivered required 0", leftover()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    fill_linear();
    set_sa_blocks();
    start_job(10'd31);
    repeat (45) @(negedge clk);
    #2;
    mon_on = 1'b0;
    reset_n = 1'b0;
    #1;
    checks += 5;
    if (shift_idle !== 1'b1) begin errors++; $display("FAIL rst_mid_idle got %b required 1", shift_idle); end
    if (sram_en !== 1'b0) begin errors++; $display("FAIL rst_mid_en got %b required 0", sram_en); end
    if (sram_addr !== 10'd0) begin errors++; $display("FAIL rst_mid_addr got %0d required 0", sram_addr); end
    if (serial_en !== '0) begin errors++; $display("FAIL rst_mid_ser_en got %h required 0", serial_en); end
    if (serial_output !== '0) begin errors++; $display("FAIL rst_mid_ser_out got %h required 0", serial_output); end
    @(negedge clk);
    reset_n = 1'b1;
    start_job(10'd31);
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_rerun_idle got busy required idle within bound"); end
    checks++;
    if (leftover() != 0) begin errors++; $display("FAIL rst_rerun_words got %0d undelivered required 0", leftover()); end
    checks++;
    if (en_cnt != 1024) begin errors++; $display("FAIL rst_rerun_reads got %0d required 1024", en_cnt); end
  endtask

  task automatic test_round_trip();
    bit ok;
    int bad;
    fill_hash();
    for (int a = 0; a < 1024; a++) dst[a] = ~mem[a];
    set_sa_blocks();
    start_job(10'd31);
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rt_idle got busy required idle within bound"); end
    bad = 0;
    for (int a = 0; a < 1024; a++) if (dst[a] !== mem[a]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rt_image got %0d differing words required 0", bad); end
  endtask

  initial begin
    test_reset();
    test_full_image();
    test_min_size();
    test_latency();
    test_wrap();
    test_start_busy();
    test_reset_mid();
    test_round_trip();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
